// File: rtl/alu_cmd_pkg.sv
// Shared constants for the ASCII ALU command parser: character codes, dtype/op encodings, FSM states.
package alu_cmd_pkg;

    localparam logic [7:0] ASCII_W   = 8'h57;
    localparam logic [7:0] ASCII_S   = 8'h53;
    localparam logic [7:0] ASCII_ADD = 8'h2B;
    localparam logic [7:0] ASCII_SUB = 8'h2D;
    localparam logic [7:0] ASCII_MUL = 8'h2A;
    localparam logic [7:0] ASCII_DIV = 8'h2F;
    localparam logic [7:0] ASCII_EQ  = 8'h3D;

    localparam logic [3:0] DTYPE_NONE     = 4'h0;
    localparam logic [3:0] DTYPE_UNSIGNED = 4'h1;
    localparam logic [3:0] DTYPE_SIGNED   = 4'h2;

    localparam logic [4:0] OP_NONE = 5'h00;
    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_MUL  = 5'h04;
    localparam logic [4:0] OP_DIV  = 5'h08;

    localparam logic [2:0] MAX_DIGITS   = 3'd4;
    // Counter value on the last tolerated WAIT cycle (255 cycles counted 0..254).
    localparam logic [7:0] TIMEOUT_LAST = 8'd254;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRC1,
        ST_SRC2,
        ST_LAUNCH,
        ST_WAIT,
        ST_ERR
    } state_t;

    function automatic logic [4:0] op_decode(input logic [7:0] ch);
        case (ch)
            ASCII_ADD: return OP_ADD;
            ASCII_SUB: return OP_SUB;
            ASCII_MUL: return OP_MUL;
            ASCII_DIV: return OP_DIV;
            default:   return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' to a nibble plus a valid flag.
module hex_ascii_decode (
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nibble = ch[3:0];
            is_hex = 1'b1;
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            // Letters share the low nibble pattern 1..6 in both cases.
            nibble = ch[3:0] + 4'h9;
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_parser.sv
// Parses "<W|S><hex1-4><op><hex1-4>=" from a UART byte stream and launches the ALU.
// Define ALU_CMD_TIMEOUT_EN to abort a WAIT that sees no alu_done within 255 cycles.
module alu_cmd_parser
    import alu_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        alu_done,
    output logic [3:0]  dtype,
    output logic [4:0]  op,
    output logic [15:0] src1,
    output logic [15:0] src2,
    output logic        start,
    output logic        busy,
    output logic        err
);

    state_t      state_reg, state_next;
    logic [3:0]  dtype_reg, dtype_next;
    logic [4:0]  op_reg, op_next;
    logic [15:0] src1_reg, src1_next;
    logic [15:0] src2_reg, src2_next;
    logic [2:0]  digits_reg, digits_next;
    logic        err_reg, err_next;

    logic [3:0]  nibble;
    logic        is_hex;
    logic [4:0]  rx_op;
    logic        digit_ok;
    logic        tmo_hit;

    hex_ascii_decode u_hex (
        .ch     (rx_data),
        .nibble (nibble),
        .is_hex (is_hex)
    );

    assign rx_op    = op_decode(rx_data);
    assign digit_ok = is_hex && (digits_reg != MAX_DIGITS);

`ifdef ALU_CMD_TIMEOUT_EN
    logic [7:0] tmo_reg, tmo_next;

    always_comb begin
        tmo_next = 8'h0;
        if (state_reg == ST_WAIT)
            tmo_next = tmo_reg + 8'h1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            tmo_reg <= 8'h0;
        else
            tmo_reg <= tmo_next;
    end

    assign tmo_hit = (state_reg == ST_WAIT) && (tmo_reg == TIMEOUT_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        dtype_next  = dtype_reg;
        op_next     = op_reg;
        src1_next   = src1_reg;
        src2_next   = src2_reg;
        digits_next = digits_reg;
        err_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_valid && (rx_data == ASCII_W || rx_data == ASCII_S)) begin
                    dtype_next  = (rx_data == ASCII_W) ? DTYPE_UNSIGNED : DTYPE_SIGNED;
                    src1_next   = 16'h0;
                    src2_next   = 16'h0;
                    digits_next = 3'd0;
                    state_next  = ST_SRC1;
                end
            end
            ST_SRC1: begin
                if (rx_valid) begin
                    if (digit_ok) begin
                        src1_next   = {src1_reg[11:0], nibble};
                        digits_next = digits_reg + 3'd1;
                    end else if (rx_op != OP_NONE && digits_reg != 3'd0) begin
                        op_next     = rx_op;
                        digits_next = 3'd0;
                        state_next  = ST_SRC2;
                    end else begin
                        op_next    = OP_NONE;
                        err_next   = 1'b1;
                        state_next = ST_ERR;
                    end
                end
            end
            ST_SRC2: begin
                if (rx_valid) begin
                    if (digit_ok) begin
                        src2_next   = {src2_reg[11:0], nibble};
                        digits_next = digits_reg + 3'd1;
                    end else if (rx_data == ASCII_EQ && digits_reg != 3'd0) begin
                        state_next = ST_LAUNCH;
                    end else begin
                        op_next    = OP_NONE;
                        err_next   = 1'b1;
                        state_next = ST_ERR;
                    end
                end
            end
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT: begin
                if (alu_done) begin
                    state_next = ST_IDLE;
                end else if (tmo_hit) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (rx_valid && rx_data == ASCII_EQ)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg  <= ST_IDLE;
            dtype_reg  <= DTYPE_NONE;
            op_reg     <= OP_NONE;
            src1_reg   <= 16'h0;
            src2_reg   <= 16'h0;
            digits_reg <= 3'd0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            dtype_reg  <= dtype_next;
            op_reg     <= op_next;
            src1_reg   <= src1_next;
            src2_reg   <= src2_next;
            digits_reg <= digits_next;
            err_reg    <= err_next;
        end
    end

    assign dtype = dtype_reg;
    assign op    = op_reg;
    assign src1  = src1_reg;
    assign src2  = src2_reg;
    assign start = (state_reg == ST_LAUNCH);
    assign busy  = (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT);
    assign err   = err_reg;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Scoreboard bench for alu_cmd_parser: a string-level grammar model predicts start/err events.
module tb_alu_cmd_parser;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        alu_done = 1'b0;
    logic [3:0]  dtype;
    logic [4:0]  op;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        start;
    logic        busy;
    logic        err;

    alu_cmd_parser dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .alu_done (alu_done),
        .dtype    (dtype),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .start    (start),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        bit          chk_op;
        logic [3:0]  dtype;
        logic [4:0]  op;
        logic [15:0] s1;
        logic [15:0] s2;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       last_launch;
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         m_mode = 0;      // 0 between commands, 1 collecting, 2 discarding to '='
    int         wait_mode = 0;   // 0 normal done, 1 reset in WAIT, 2 withhold done
    logic [7:0] cmd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_hex_ch(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic int hex_val(input logic [7:0] c);
        if (c <= 8'h39) return int'(c) - 48;
        if (c <= 8'h46) return int'(c) - 55;
        return int'(c) - 87;
    endfunction

    function automatic logic [4:0] op_of(input logic [7:0] c);
        case (c)
            8'h2B:   return 5'h01;
            8'h2D:   return 5'h02;
            8'h2A:   return 5'h04;
            8'h2F:   return 5'h08;
            default: return 5'h00;
        endcase
    endfunction

    // 0 = valid so far, 1 = complete command, 2 = broken
    function automatic int judge();
        int n, p, r;
        n = cmd_q.size();
        p = 1;
        while (p < n && is_hex_ch(cmd_q[p])) p++;
        if (p == n) return (n - 1 <= 4) ? 0 : 2;
        if (p == 1 || p - 1 > 4 || op_of(cmd_q[p]) == 5'h00) return 2;
        r = p + 1;
        while (r < n && is_hex_ch(cmd_q[r])) r++;
        if (r == n) return (r - p - 1 <= 4) ? 0 : 2;
        if (r == p + 1 || r - p - 1 > 4 || cmd_q[r] != 8'h3D) return 2;
        return 1;
    endfunction

    task automatic model_byte(input logic [7:0] c, output bit launched);
        exp_t e;
        int   v, p, a;
        launched = 1'b0;
        if (m_mode == 0) begin
            if (c == 8'h57 || c == 8'h53) begin
                cmd_q.delete();
                cmd_q.push_back(c);
                m_mode = 1;
            end
        end else if (m_mode == 2) begin
            if (c == 8'h3D) m_mode = 0;
        end else begin
            cmd_q.push_back(c);
            v = judge();
            e.is_err = 1'b0; e.chk_op = 1'b1;
            e.dtype = 4'h0; e.op = 5'h00; e.s1 = 16'h0; e.s2 = 16'h0;
            if (v == 2) begin
                e.is_err = 1'b1;
                exp_q.push_back(e);
                m_mode = 2;
            end else if (v == 1) begin
                e.dtype = (cmd_q[0] == 8'h57) ? 4'h1 : 4'h2;
                p = 1;
                a = 0;
                while (is_hex_ch(cmd_q[p])) begin a = a * 16 + hex_val(cmd_q[p]); p++; end
                e.s1 = 16'(a);
                e.op = op_of(cmd_q[p]);
                a = 0;
                for (int i = p + 1; i < cmd_q.size() - 1; i++) a = a * 16 + hex_val(cmd_q[i]);
                e.s2 = 16'(a);
                exp_q.push_back(e);
                last_launch = e;
                launched = 1'b1;
                m_mode = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        cmd_q.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (n_rst && (start || err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: start=%0b err=%0b, required no event", start, err);
            end else begin
                mon_e = exp_q.pop_front();
                $display("event start=%0b err=%0b dtype=%0h op=%0h src1=%0h src2=%0h", start, err, dtype, op, src1, src2);
                check("event_is_err", 32'(err), 32'(mon_e.is_err));
                check("event_is_start", 32'(start), 32'(!mon_e.is_err));
                if (!mon_e.is_err) begin
                    check("start_dtype", 32'(dtype), 32'(mon_e.dtype));
                    check("start_op", 32'(op), 32'(mon_e.op));
                    check("start_src1", 32'(src1), 32'(mon_e.s1));
                    check("start_src2", 32'(src2), 32'(mon_e.s2));
                end else if (mon_e.chk_op) begin
                    check("err_op_cleared", 32'(op), 32'h0);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic raw_byte(input logic [7:0] c);
        @(posedge clk); #1;
        rx_data = c;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_held(input string tag);
        check({tag, "_dtype"}, 32'(dtype), 32'(last_launch.dtype));
        check({tag, "_op"}, 32'(op), 32'(last_launch.op));
        check({tag, "_src1"}, 32'(src1), 32'(last_launch.s1));
        check({tag, "_src2"}, 32'(src2), 32'(last_launch.s2));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dtype"}, 32'(dtype), 32'h0);
        check({tag, "_op"}, 32'(op), 32'h0);
        check({tag, "_src1"}, 32'(src1), 32'h0);
        check({tag, "_src2"}, 32'(src2), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_start"}, 32'(start), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
    endtask

    task automatic pulse_done();
        alu_done = 1'b1;
        @(posedge clk); #1;
        alu_done = 1'b0;
        check("busy_low_after_done", 32'(busy), 32'h0);
        check_held("held_after_done");
    endtask

    task automatic handle_wait();
        int k;
        check("start_latency", 32'(start), 32'h1);
        check("busy_with_start", 32'(busy), 32'h1);
        @(posedge clk); #1;
        check("start_one_cycle", 32'(start), 32'h0);
        check("busy_in_wait", 32'(busy), 32'h1);
        if (wait_mode == 1) begin
            repeat (2) @(posedge clk);
            #1 n_rst = 1'b0;
            #1;
            model_reset();
            check_reset_outputs("reset_in_wait");
            @(posedge clk); #1;
            n_rst = 1'b1;
        end else if (wait_mode == 2) begin
`ifdef ALU_CMD_TIMEOUT_EN
            exp_q.push_back('{is_err: 1'b1, chk_op: 1'b0, dtype: 4'h0, op: 5'h0, s1: 16'h0, s2: 16'h0});
            k = 1;
            while (busy && k < 400) begin
                @(posedge clk); #1;
                k++;
            end
            check("timeout_busy_cycles", 32'(k), 32'd256);
            check("timeout_err", 32'(err), 32'h1);
`else
            k = 0;
            repeat (300) @(posedge clk);
            #1;
            check("wait_persists", 32'(busy), 32'h1);
            check_held("held_long_wait");
            pulse_done();
`endif
        end else begin
            repeat (2) raw_byte(8'($urandom_range(0, 255)));
            raw_byte(8'h57);
            raw_byte(8'h3D);
            check("busy_ignores_bytes", 32'(busy), 32'h1);
            check_held("wait_stable");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            pulse_done();
        end
    endtask

    task automatic send_byte(input logic [7:0] c);
        bit launched;
        @(posedge clk); #1;
        rx_data = c;
        rx_valid = 1'b1;
        model_byte(c, launched);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        if (launched)
            handle_wait();
        else
            repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // ---------------- main sequence ----------------
    string hex_chars = "0123456789ABCDEFabcdef";
    string op_chars  = "+-*/";

    initial begin
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;

        send_str("W12+34=");
        send_str("SFFFF-0001=");
        send_str("W12345");
        send_str("=W2*3=");
        send_str("S+5=");
        send_str("Wa/b=");

        // alu_done while idle must be ignored
        @(posedge clk); #1;
        alu_done = 1'b1;
        @(posedge clk); #1;
        alu_done = 1'b0;
        check("idle_done_busy", 32'(busy), 32'h0);

        // reset mid-command
        send_str("W1+");
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("reset_mid_cmd");
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        send_str("2=");
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("after_reset_2eq");

        // reset during WAIT
        wait_mode = 1;
        send_str("W5*7=");
        wait_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("after_wait_reset_busy", 32'(busy), 32'h0);

        // randomized commands
        for (int t = 0; t < 40; t++) begin
            int n1, n2;
            n1 = $urandom_range(0, 9);
            if (n1 > 5) n1 = $urandom_range(1, 4);
            n2 = $urandom_range(0, 9);
            if (n2 > 5) n2 = $urandom_range(1, 4);
            if ($urandom_range(0, 9) == 0)
                send_byte(8'($urandom_range(0, 255)));
            else
                send_byte(($urandom_range(0, 1) == 0) ? 8'h57 : 8'h53);
            for (int i = 0; i < n1; i++) send_byte(hex_chars[$urandom_range(0, 21)]);
            if ($urandom_range(0, 9) == 0)
                send_byte(8'($urandom_range(0, 255)));
            else
                send_byte(op_chars[$urandom_range(0, 3)]);
            for (int i = 0; i < n2; i++) send_byte(hex_chars[$urandom_range(0, 21)]);
            send_byte(8'h3D);
            for (int g = 0; g < 3 && m_mode != 0; g++) send_byte(8'h3D);
        end

        // WAIT with alu_done withheld
        wait_mode = 2;
        send_str("W1+1=");
        wait_mode = 0;

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
